ps2_scancode_decoder: RTL and testbench

//  Downstream consumer of the PS/2 keyboard receiver FIFO. Pops raw Set-2 bytes via the

---
 rtl/ps2_scancode_decoder.sv | 160 ++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: pops receiver FIFO bytes and emits key events.
// Optional ASCII lookup built when SCANCODE_ASCII_EN is defined.
module ps2_scancode_decoder #(
  parameter int PCNT_W        = 8,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_ready,
  input  logic [7:0]        ps2_data,
  input  logic              ps2_overflow,
  output logic              ps2_nextdata_n,
  output logic              key_valid,
  output logic [7:0]        key_code,
  output logic              key_ext,
  output logic              key_make,
  output logic              key_held,
  output logic [7:0]        held_code,
  output logic [PCNT_W-1:0] press_count,
  output logic              overflow_flag,
  output logic [7:0]        ascii
);

  typedef enum logic [1:0] {
    IDLE, EXT, BRK, EXTBRK
  } state_t;

  state_t state, nxt;
  logic   take, pop, held_ext;
  logic   is_make, is_brk, ev_ext;
  logic   same_held, fire_make, fire_brk;

  always_comb begin
    nxt     = state;
    is_make = 1'b0;
    is_brk  = 1'b0;
    ev_ext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ps2_data == 8'hE0) nxt = EXT;
        else if (ps2_data == 8'hF0) nxt = BRK;
        else if (!(ps2_data inside
                 {8'h00, 8'hAA, 8'hEE,
                  8'hFA, 8'hFE, 8'hFF}))
          is_make = 1'b1;
      end
      EXT: begin
        if (ps2_data == 8'hF0) nxt = EXTBRK;
        else if (ps2_data != 8'hE0) begin
          is_make = 1'b1;
          ev_ext  = 1'b1;
          nxt     = IDLE;
        end
      end
      BRK: begin
        nxt    = IDLE;
        is_brk = !(ps2_data inside {8'hE0, 8'hF0});
      end
      default: begin
        nxt    = IDLE;
        ev_ext = 1'b1;
        is_brk = !(ps2_data inside {8'hE0, 8'hF0});
      end
    endcase
  end

  // Overflow wins: the byte is still popped but never decoded.
  assign take      = ps2_ready & ps2_nextdata_n;
  assign pop       = take & ~ps2_overflow;
  assign same_held = key_held &&
    ({held_ext, held_code} == {ev_ext, ps2_data});
  assign fire_make = pop & is_make &
    (!same_held || (FILTER_REPEAT == 1'b0));
  assign fire_brk  = pop & is_brk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ps2_nextdata_n <= 1'b1;
      key_valid      <= 1'b0;
      key_code       <= 8'h00;
      key_ext        <= 1'b0;
      key_make       <= 1'b0;
      key_held       <= 1'b0;
      held_code      <= 8'h00;
      held_ext       <= 1'b0;
      press_count    <= '0;
      overflow_flag  <= 1'b0;
    end else begin
      key_valid      <= 1'b0;
      ps2_nextdata_n <= ~take;
      if (ps2_overflow) begin
        overflow_flag <= 1'b1;
        state         <= IDLE;
      end else if (take) begin
        state <= nxt;
      end
      if (fire_make) begin
        key_valid   <= 1'b1;
        key_code    <= ps2_data;
        key_ext     <= ev_ext;
        key_make    <= 1'b1;
        key_held    <= 1'b1;
        held_code   <= ps2_data;
        held_ext    <= ev_ext;
        press_count <= press_count + PCNT_W'(1);
      end
      if (fire_brk) begin
        key_valid <= 1'b1;
        key_code  <= ps2_data;
        key_ext   <= ev_ext;
        key_make  <= 1'b0;
        if (same_held) begin
          key_held  <= 1'b0;
          held_code <= 8'h00;
          held_ext  <= 1'b0;
        end
      end
    end
  end

`ifdef SCANCODE_ASCII_EN
  function automatic logic [7:0] ascii_of(
    input logic [7:0] c
  );
    case (c)
      8'h1C: return 8'h61; 8'h32: return 8'h62;
      8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66;
      8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A;
      8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E;
      8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72;
      8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76;
      8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31;
      8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35;
      8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20; 8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      ascii <= 8'h00;
    else if (fire_make || fire_brk)
      ascii <= ev_ext ? 8'h00 : ascii_of(ps2_data);
  end
`else
  assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: vector table plus
// hand-written overflow, reset and streaming sequences.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_ready = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_overflow = 1'b0;
  logic       ps2_nextdata_n, key_valid, key_ext, key_make;
  logic       key_held, overflow_flag;
  logic [7:0] key_code, held_code, press_count, ascii;

  logic       nf_nd_n, nf_valid, nf_ext, nf_make, nf_held, nf_ovf;
  logic [7:0] nf_code, nf_hcode, nf_count, nf_ascii;

`ifdef SCANCODE_ASCII_EN
  localparam bit ASC = 1'b1;
`else
  localparam bit ASC = 1'b0;
`endif

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.PCNT_W(8), .FILTER_REPEAT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ps2_ready(ps2_ready), .ps2_data(ps2_data),
    .ps2_overflow(ps2_overflow),
    .ps2_nextdata_n(ps2_nextdata_n),
    .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_make(key_make),
    .key_held(key_held), .held_code(held_code),
    .press_count(press_count),
    .overflow_flag(overflow_flag), .ascii(ascii)
  );

  ps2_scancode_decoder #(.PCNT_W(8), .FILTER_REPEAT(1'b0)) nf (
    .clk(clk), .rst(rst),
    .ps2_ready(ps2_ready), .ps2_data(ps2_data),
    .ps2_overflow(ps2_overflow),
    .ps2_nextdata_n(nf_nd_n),
    .key_valid(nf_valid), .key_code(nf_code),
    .key_ext(nf_ext), .key_make(nf_make),
    .key_held(nf_held), .held_code(nf_hcode),
    .press_count(nf_count),
    .overflow_flag(nf_ovf), .ascii(nf_ascii)
  );

  typedef struct {
    bit         rst;
    logic [7:0] data;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       make;
    logic       held;
    logic [7:0] hcode;
    logic [7:0] cnt;
    logic [7:0] nfcnt;
    logic [7:0] asc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input bit r, input logic [7:0] d, input logic e,
    input logic [7:0] c, input logic x, input logic m,
    input logic h, input logic [7:0] hc,
    input logic [7:0] n, input logic [7:0] nn,
    input logic [7:0] a
  );
    vec_t v;
    v.rst = r; v.data = d; v.ev = e; v.code = c;
    v.ext = x; v.make = m; v.held = h; v.hcode = hc;
    v.cnt = n; v.nfcnt = nn; v.asc = a;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " nextdata_n"}, 32'(ps2_nextdata_n), 1);
    chk({tag, " key_valid"}, 32'(key_valid), 0);
    chk({tag, " key_code"}, 32'(key_code), 0);
    chk({tag, " key_ext"}, 32'(key_ext), 0);
    chk({tag, " key_make"}, 32'(key_make), 0);
    chk({tag, " key_held"}, 32'(key_held), 0);
    chk({tag, " held_code"}, 32'(held_code), 0);
    chk({tag, " press_count"}, 32'(press_count), 0);
    chk({tag, " overflow_flag"}, 32'(overflow_flag), 0);
    chk({tag, " ascii"}, 32'(ascii), 0);
  endtask

  task automatic do_reset();
    ps2_ready    = 1'b0;
    ps2_overflow = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Capture edge: outputs sampled 1 time unit later.
  task automatic send(input logic [7:0] b);
    ps2_data  = b;
    ps2_ready = 1'b1;
    @(posedge clk); #1;
    ps2_ready = 1'b0;
    chk("pop low", 32'(ps2_nextdata_n), 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    chk("pop one clk", 32'(ps2_nextdata_n), 1);
    chk("valid one clk", 32'(key_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int         idx, nev, cyc;

    // rst data ev code ext make held hcode cnt nfcnt asc
    tbl.push_back(mk(1, 8'h1C, 1, 8'h1C, 0, 1, 1, 8'h1C, 1, 1, 8'h61));
    tbl.push_back(mk(0, 8'h1C, 0, 8'h00, 0, 0, 1, 8'h1C, 1, 2, 8'h00));
    tbl.push_back(mk(0, 8'h1C, 0, 8'h00, 0, 0, 1, 8'h1C, 1, 3, 8'h00));
    tbl.push_back(mk(0, 8'hF0, 0, 8'h00, 0, 0, 1, 8'h1C, 1, 3, 8'h00));
    tbl.push_back(mk(0, 8'h1C, 1, 8'h1C, 0, 0, 0, 8'h00, 1, 3, 8'h61));
    tbl.push_back(mk(1, 8'hE0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h75, 1, 8'h75, 1, 1, 1, 8'h75, 1, 1, 8'h00));
    tbl.push_back(mk(0, 8'hE0, 0, 8'h00, 0, 0, 1, 8'h75, 1, 1, 8'h00));
    tbl.push_back(mk(0, 8'hF0, 0, 8'h00, 0, 0, 1, 8'h75, 1, 1, 8'h00));
    tbl.push_back(mk(0, 8'h75, 1, 8'h75, 1, 0, 0, 8'h00, 1, 1, 8'h00));
    tbl.push_back(mk(1, 8'hAA, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'hFA, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'hF0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'hE0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h15, 1, 8'h15, 0, 1, 1, 8'h15, 1, 1, 8'h71));
    tbl.push_back(mk(0, 8'h23, 1, 8'h23, 0, 1, 1, 8'h23, 2, 2, 8'h64));
    tbl.push_back(mk(0, 8'hF0, 0, 8'h00, 0, 0, 1, 8'h23, 2, 2, 8'h00));
    tbl.push_back(mk(0, 8'h15, 1, 8'h15, 0, 0, 1, 8'h23, 2, 2, 8'h71));

    do_reset();
    chk_reset("reset");

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].data);
      chk("key_valid", 32'(key_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("key_code", 32'(key_code), 32'(tbl[i].code));
        chk("key_ext", 32'(key_ext), 32'(tbl[i].ext));
        chk("key_make", 32'(key_make), 32'(tbl[i].make));
        chk("ascii", 32'(ascii),
            ASC ? 32'(tbl[i].asc) : 32'h0);
      end
      chk("key_held", 32'(key_held), 32'(tbl[i].held));
      chk("held_code", 32'(held_code), 32'(tbl[i].hcode));
      chk("press_count", 32'(press_count), 32'(tbl[i].cnt));
      chk("nf press_count", 32'(nf_count), 32'(tbl[i].nfcnt));
      tick();
    end

    // Overflow between prefix and key aborts the prefix.
    do_reset();
    send(8'hE0);
    tick();
    ps2_overflow = 1'b1;
    @(posedge clk); #1;
    ps2_overflow = 1'b0;
    chk("ovf set", 32'(overflow_flag), 1);
    send(8'h15);
    chk("ovf ev", 32'(key_valid), 1);
    chk("ovf ext", 32'(key_ext), 0);
    chk("ovf code", 32'(key_code), 32'h15);
    tick();
    chk("ovf sticky", 32'(overflow_flag), 1);

    // Byte captured on an overflow edge is popped, not decoded.
    ps2_data     = 8'h1C;
    ps2_ready    = 1'b1;
    ps2_overflow = 1'b1;
    @(posedge clk); #1;
    ps2_ready    = 1'b0;
    ps2_overflow = 1'b0;
    chk("ovf pop", 32'(ps2_nextdata_n), 0);
    chk("ovf drop", 32'(key_valid), 0);
    tick();
    chk("ovf held", 32'(held_code), 32'h15);

    // Reset mid-prefix.
    send(8'hE0);
    tick();
    do_reset();
    chk_reset("rst mid E0");
    send(8'h23);
    chk("post rst ev", 32'(key_valid), 1);
    chk("post rst ext", 32'(key_ext), 0);
    chk("post rst code", 32'(key_code), 32'h23);
    chk("post rst cnt", 32'(press_count), 1);
    tick();

    // Continuous stream: ready never drops.
    do_reset();
    for (int i = 0; i < 256; i++)
      q.push_back((i % 2 == 0) ? 8'h15 : 8'h23);
    idx = 0; nev = 0; cyc = 0;
    ps2_data  = q[0];
    ps2_ready = 1'b1;
    while (idx < 256 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (!ps2_nextdata_n) idx++;
      if (key_valid && nev < 256) begin
        chk("stream code", 32'(key_code), 32'(q[nev]));
        nev++;
        chk("stream count", 32'(press_count),
            32'(nev % 256));
      end
      if (idx < 256) ps2_data = q[idx];
      else ps2_ready = 1'b0;
    end
    ps2_ready = 1'b0;
    chk("stream cycles", 32'(cyc), 511);
    chk("stream events", 32'(nev), 256);
    chk("stream wrap", 32'(press_count), 0);
    chk("nf stream wrap", 32'(nf_count), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
